register_file_mp: RTL and testbench

Parametrised multi-port register file for the datapath. It generalises the single-write, dual-read file in three ways: configurable width, depth and port counts; optional same-cycle write-to-read bypass; and a per-register busy scoreboard used by hazard logic. It sits between decode, where reads and reservations happen, and writeback, where writes happen.

---
 rtl/register_file_mp.sv | 140 ++++++++++++++
 tb/tb_register_file_mp.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// register_file_mp
// ----------------
// Multi-port flop-based register file with optional same-cycle write-to-read
// bypass and a per-register busy scoreboard for hazard detection.
// Reads and reservations come from decode; writes come from writeback.
//
// Parameters:
//   DATA_W   register width in bits
//   DEPTH    number of registers (power of two, >= 2)
//   NREAD    number of read ports (>= 1)
//   NWRITE   number of write ports (>= 1)
//   ZERO_REG 1 = register 0 reads as zero and ignores writes and reservations
//   BYPASS   1 = reads return same-cycle write data
//
// Ports:
//   CLK      clock, all state updates on the rising edge
//   nRST     synchronous active-low reset
//   wen      per-port write enable
//   wsel     write addresses, port k at [k*AW +: AW]
//   wdat     write data, port k at [k*DATA_W +: DATA_W]
//   rsel     read addresses, port j at [j*AW +: AW]
//   rdat     read data (combinational), port j at [j*DATA_W +: DATA_W]
//   rbusy    busy flag of each addressed register (combinational)
//   rsv_en   mark register rsv_sel busy
//   rsv_sel  register to reserve
//   flush    clear every busy bit
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NWRITE-1:0]        wen,
  input  logic [NWRITE*AW-1:0]     wsel,
  input  logic [NWRITE*DATA_W-1:0] wdat,
  input  logic [NREAD*AW-1:0]      rsel,
  output logic [NREAD*DATA_W-1:0]  rdat,
  output logic [NREAD-1:0]         rbusy,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_sel,
  input  logic                     flush
);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  // A write is effective unless it targets the hard-wired zero register.
  function automatic logic write_effective(input logic en, input logic [AW-1:0] sel);
    return en && !((ZERO_REG != 0) && (sel == '0));
  endfunction

  // Next register contents. Ports are walked in ascending order so the
  // highest-index port targeting an address is the one that sticks.
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NWRITE; k++) begin
      if (write_effective(wen[k], wsel[k*AW +: AW])) begin
        regs_d[wsel[k*AW +: AW]] = wdat[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next busy scoreboard. Writes release first so that a reservation in the
  // same cycle overrides them (the new producer supersedes the finishing one);
  // flush overrides everything, including that cycle's reservation.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWRITE; k++) begin
      if (write_effective(wen[k], wsel[k*AW +: AW])) begin
        busy_d[wsel[k*AW +: AW]] = 1'b0;
      end
    end
    if (flush) begin
      busy_d = '0;
    end else if (rsv_en) begin
      busy_d[rsv_sel] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Read ports. The bypass path scans all write ports so the last matching
  // port wins, matching the write priority. A bypassed register only reports
  // busy if it is being re-reserved in the same cycle, in which case the
  // stored bit (the pending producer's state) is what hazard logic should see.
  always_comb begin
    rdat  = '0;
    rbusy = '0;
    for (int j = 0; j < NREAD; j++) begin
      logic [AW-1:0]     sel;
      logic [DATA_W-1:0] rd;
      logic              bz;
      logic              hit;
      sel = rsel[j*AW +: AW];
      rd  = regs_q[sel];
      bz  = busy_q[sel];
      hit = 1'b0;
      if (BYPASS != 0) begin
        for (int k = 0; k < NWRITE; k++) begin
          if (wen[k] && (wsel[k*AW +: AW] == sel)) begin
            hit = 1'b1;
            rd  = wdat[k*DATA_W +: DATA_W];
          end
        end
        if (hit) begin
          bz = (rsv_en && (rsv_sel == sel)) ? busy_q[sel] : 1'b0;
        end
      end
      if ((ZERO_REG != 0) && (sel == '0)) begin
        rd = '0;
        bz = 1'b0;
      end
      if (!nRST) begin
        rd = '0;
        bz = 1'b0;
      end
      rdat[j*DATA_W +: DATA_W] = rd;
      rbusy[j]                 = bz;
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp
// -------------------
// Drives two register_file_mp instances from the same stimulus:
//   dut_a: ZERO_REG=1, BYPASS=1, NWRITE=2
//   dut_b: ZERO_REG=0, BYPASS=0, NWRITE=2
// Each cycle record carries the inputs plus the hand-derived outputs both
// instances must show during that cycle, before the next rising edge.
module tb_register_file_mp;

  logic        CLK;
  logic        nRST;
  logic [1:0]  wen;
  logic [9:0]  wsel;
  logic [63:0] wdat;
  logic [9:0]  rsel;
  logic        rsv_en;
  logic [4:0]  rsv_sel;
  logic        flush;
  logic [63:0] rdat_a, rdat_b;
  logic [1:0]  rbusy_a, rbusy_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic        nrst;
    logic [1:0]  wen;
    logic [4:0]  wsel0, wsel1;
    logic [31:0] wdat0, wdat1;
    logic        rsv_en;
    logic [4:0]  rsv_sel;
    logic        flush;
    logic [4:0]  rsel0, rsel1;
    logic [31:0] a_rd0, a_rd1;
    logic [1:0]  a_bz;
    logic [31:0] b_rd0, b_rd1;
    logic [1:0]  b_bz;
  } vec_t;

  vec_t tbl[$];
  vec_t expq[$];

  register_file_mp #(.DATA_W(32), .DEPTH(32), .NREAD(2), .NWRITE(2),
                     .ZERO_REG(1), .BYPASS(1)) dut_a (
    .CLK(CLK), .nRST(nRST), .wen(wen), .wsel(wsel), .wdat(wdat),
    .rsel(rsel), .rdat(rdat_a), .rbusy(rbusy_a),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .flush(flush)
  );

  register_file_mp #(.DATA_W(32), .DEPTH(32), .NREAD(2), .NWRITE(2),
                     .ZERO_REG(0), .BYPASS(0)) dut_b (
    .CLK(CLK), .nRST(nRST), .wen(wen), .wsel(wsel), .wdat(wdat),
    .rsel(rsel), .rdat(rdat_b), .rbusy(rbusy_b),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .flush(flush)
  );

  // Free-running clock; rising edges at 5, 15, 25 ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Fully general record builder, used by the hand-written sequences.
  function automatic vec_t full(string name, logic nrst, logic [1:0] w,
      logic [4:0] ws0, logic [31:0] wd0, logic [4:0] ws1, logic [31:0] wd1,
      logic rsv, logic [4:0] rs, logic fl, logic [4:0] r0, logic [4:0] r1,
      logic [31:0] ard0, logic [31:0] ard1, logic [1:0] abz,
      logic [31:0] brd0, logic [31:0] brd1, logic [1:0] bbz);
    vec_t v;
    v.name = name;   v.nrst = nrst;   v.wen = w;
    v.wsel0 = ws0;   v.wdat0 = wd0;   v.wsel1 = ws1;  v.wdat1 = wd1;
    v.rsv_en = rsv;  v.rsv_sel = rs;  v.flush = fl;
    v.rsel0 = r0;    v.rsel1 = r1;
    v.a_rd0 = ard0;  v.a_rd1 = ard1;  v.a_bz = abz;
    v.b_rd0 = brd0;  v.b_rd1 = brd1;  v.b_bz = bbz;
    return v;
  endfunction

  // Table row: both read ports address the same register.
  function automatic vec_t row(string name, logic nrst, logic [1:0] w,
      logic [4:0] ws0, logic [31:0] wd0, logic [4:0] ws1, logic [31:0] wd1,
      logic rsv, logic [4:0] rs, logic fl, logic [4:0] r,
      logic [31:0] ard, logic abz, logic [31:0] brd, logic bbz);
    return full(name, nrst, w, ws0, wd0, ws1, wd1, rsv, rs, fl, r, r,
                ard, ard, {abz, abz}, brd, brd, {bbz, bbz});
  endfunction

  // Idle row: no write, reserve or flush.
  function automatic vec_t idle(string name, logic [4:0] r,
      logic [31:0] ard, logic abz, logic [31:0] brd, logic bbz);
    return row(name, 1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
               r, ard, abz, brd, bbz);
  endfunction

  task automatic cmp(input string name, input string rec,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s/%s: got %h, expected %h", rec, name, act, exp);
    end
  endtask

  // Drive one cycle's inputs away from the rising edge and queue the outputs
  // that cycle must produce.
  task automatic applyStimulus(input vec_t v);
    @(negedge CLK);
    nRST    = v.nrst;
    wen     = v.wen;
    wsel    = {v.wsel1, v.wsel0};
    wdat    = {v.wdat1, v.wdat0};
    rsv_en  = v.rsv_en;
    rsv_sel = v.rsv_sel;
    flush   = v.flush;
    rsel    = {v.rsel1, v.rsel0};
    expq.push_back(v);
  endtask

  // Sample just before the next rising edge and compare against the queue.
  task automatic checkOutput();
    vec_t v;
    #4;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    checks--;
    v = expq.pop_front();
    cmp("a_rdat0", v.name, rdat_a[31:0],  v.a_rd0);
    cmp("a_rdat1", v.name, rdat_a[63:32], v.a_rd1);
    cmp("a_rbusy", v.name, {30'd0, rbusy_a}, {30'd0, v.a_bz});
    cmp("b_rdat0", v.name, rdat_b[31:0],  v.b_rd0);
    cmp("b_rdat1", v.name, rdat_b[63:32], v.b_rd1);
    cmp("b_rbusy", v.name, {30'd0, rbusy_b}, {30'd0, v.b_bz});
  endtask

  initial begin
    nRST = 1'b0; wen = '0; wsel = '0; wdat = '0; rsel = '0;
    rsv_en = 1'b0; rsv_sel = '0; flush = 1'b0;

    // Reset, preload and reset again.
    tbl.push_back(row("rst0", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle("post_rst", 5, 0, 0, 0, 0));
    tbl.push_back(row("pre_wr5", 1, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5,
                      32'hDEADBEEF, 0, 32'h0, 0));
    tbl.push_back(row("pre_rsv5", 1, 2'b00, 0, 0, 0, 0, 1, 5, 0, 5,
                      32'hDEADBEEF, 0, 32'hDEADBEEF, 0));
    tbl.push_back(row("in_rst", 0, 2'b01, 5, 32'h11111111, 0, 0, 1, 6, 0, 5,
                      0, 0, 0, 0));
    tbl.push_back(idle("after_rst5", 5, 0, 0, 0, 0));
    tbl.push_back(idle("after_rst6", 6, 0, 0, 0, 0));
    // Write then read.
    tbl.push_back(row("wr7", 1, 2'b01, 7, 32'h12345678, 0, 0, 0, 0, 0, 7,
                      32'h12345678, 0, 32'h0, 0));
    tbl.push_back(idle("rd7", 7, 32'h12345678, 0, 32'h12345678, 0));
    // Both write ports on one register: port 1 wins.
    tbl.push_back(row("wr3_both", 1, 2'b11, 3, 32'hAAAAAAAA, 3, 32'h55555555,
                      0, 0, 0, 3, 32'h55555555, 0, 32'h0, 0));
    tbl.push_back(idle("rd3", 3, 32'h55555555, 0, 32'h55555555, 0));
    // Register 0: hard zero in dut_a, ordinary register in dut_b.
    tbl.push_back(row("wr0_rsv0", 1, 2'b01, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 0,
                      0, 0, 0, 0));
    tbl.push_back(idle("rd0", 0, 0, 0, 32'hFFFFFFFF, 1));
    // Scoreboard on register 9.
    tbl.push_back(row("rsv9", 1, 2'b00, 0, 0, 0, 0, 1, 9, 0, 9, 0, 0, 0, 0));
    tbl.push_back(idle("busy9_a", 9, 0, 1, 0, 1));
    tbl.push_back(idle("busy9_b", 9, 0, 1, 0, 1));
    tbl.push_back(idle("busy9_c", 9, 0, 1, 0, 1));
    tbl.push_back(row("wr9_rsv9", 1, 2'b01, 9, 32'h99, 0, 0, 1, 9, 0, 9,
                      32'h99, 1, 32'h0, 1));
    tbl.push_back(idle("still_busy9", 9, 32'h99, 1, 32'h99, 1));
    tbl.push_back(row("wr9", 1, 2'b01, 9, 32'h9A, 0, 0, 0, 0, 0, 9,
                      32'h9A, 0, 32'h99, 1));
    tbl.push_back(idle("free9", 9, 32'h9A, 0, 32'h9A, 0));
    // Flush beats a coincident reservation.
    tbl.push_back(row("rsv1", 1, 2'b00, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(row("rsv2", 1, 2'b00, 0, 0, 0, 0, 1, 2, 0, 1, 0, 1, 0, 1));
    tbl.push_back(row("rsv31", 1, 2'b00, 0, 0, 0, 0, 1, 31, 0, 2, 0, 1, 0, 1));
    tbl.push_back(row("flush_rsv4", 1, 2'b00, 0, 0, 0, 0, 1, 4, 1, 31,
                      0, 1, 0, 1));
    tbl.push_back(idle("fl_1", 1, 0, 0, 0, 0));
    tbl.push_back(idle("fl_2", 2, 0, 0, 0, 0));
    tbl.push_back(idle("fl_4", 4, 0, 0, 0, 0));
    tbl.push_back(idle("fl_31", 31, 0, 0, 0, 0));
    tbl.push_back(idle("fl_0", 0, 0, 0, 32'hFFFFFFFF, 0));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput();
    end

    // Independent read ports, two writes to different registers.
    applyStimulus(full("wr10_11", 1, 2'b11, 10, 32'hA0, 11, 32'hB1, 0, 0, 0,
                       11, 10, 32'hB1, 32'hA0, 2'b00, 32'h0, 32'h0, 2'b00));
    checkOutput();
    applyStimulus(full("rd11_10", 1, 2'b00, 0, 0, 0, 0, 0, 0, 0,
                       11, 10, 32'hB1, 32'hA0, 2'b00, 32'hB1, 32'hA0, 2'b00));
    checkOutput();
    // Disabled port 1 targeting the same register must not interfere.
    applyStimulus(full("wr10_p1off", 1, 2'b01, 10, 32'hC0, 10, 32'hDD, 0, 0, 0,
                       3, 10, 32'h55555555, 32'hC0, 2'b00,
                       32'h55555555, 32'hA0, 2'b00));
    checkOutput();
    applyStimulus(full("rd10_9", 1, 2'b00, 0, 0, 0, 0, 0, 0, 0,
                       10, 9, 32'hC0, 32'h9A, 2'b00, 32'hC0, 32'h9A, 2'b00));
    checkOutput();
    // Per-port busy flags and a write racing a reserve of another register.
    applyStimulus(full("rsv12", 1, 2'b00, 0, 0, 0, 0, 1, 12, 0,
                       12, 12, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00));
    checkOutput();
    applyStimulus(full("rd12_11", 1, 2'b00, 0, 0, 0, 0, 0, 0, 0,
                       12, 11, 32'h0, 32'hB1, 2'b01, 32'h0, 32'hB1, 2'b01));
    checkOutput();
    applyStimulus(full("wr12_rsv11", 1, 2'b01, 12, 32'hCC, 0, 0, 1, 11, 0,
                       12, 11, 32'hCC, 32'hB1, 2'b00, 32'h0, 32'hB1, 2'b01));
    checkOutput();
    applyStimulus(full("rd12_11b", 1, 2'b00, 0, 0, 0, 0, 0, 0, 0,
                       12, 11, 32'hCC, 32'hB1, 2'b10, 32'hCC, 32'hB1, 2'b10));
    checkOutput();

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0",
               expq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
